// File: rtl/edge_to_en_if.sv
// -----------------------------------------------------------------------------
// edge_to_en_if
//   Bundles the level input and the three edge-pulse outputs of edge_to_en.
//   There is no handshake: data_i is a free-running level and the outputs are
//   single-cycle pulses in the clk_i domain.
//
//   Signals (directions as seen by the detector):
//     data_i     [WIDTH-1:0]  level input(s), may be asynchronous
//     pos_edge_o [WIDTH-1:0]  one-cycle pulse per bit on 0->1
//     neg_edge_o [WIDTH-1:0]  one-cycle pulse per bit on 1->0
//     any_edge_o [WIDTH-1:0]  one-cycle pulse per bit on any transition
//
//   Modports:
//     master : the producer of the level, consumer of the pulses
//     slave  : the edge detector itself
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface edge_to_en_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] data_i;
    logic [WIDTH-1:0] pos_edge_o;
    logic [WIDTH-1:0] neg_edge_o;
    logic [WIDTH-1:0] any_edge_o;

    modport master (
        output data_i,
        input  pos_edge_o,
        input  neg_edge_o,
        input  any_edge_o
    );

    modport slave (
        input  data_i,
        output pos_edge_o,
        output neg_edge_o,
        output any_edge_o
    );
endinterface

// File: rtl/edge_to_en.sv
// -----------------------------------------------------------------------------
// edge_to_en
//   Per-bit synchronous edge detector. Each bit of bus.data_i passes through
//   SYNC_STAGES synchronizer flops and one history flop; the pulses are
//   combinational from the synchronized level (cur) and the history (prev):
//     pos = cur & ~prev, neg = ~cur & prev, any = cur ^ prev.
//   With SYNC_STAGES=0 the raw input is used as cur, so pulses appear in the
//   same cycle the input changes.
//
//   Ports:
//     clk_i  the only clock, all flops on its rising edge
//     rst_i  synchronous active-high reset; loads RESET_VAL into every
//            synchronizer and history flop and forces all outputs to 0
//     bus    edge_to_en_if.slave (data_i in, pos/neg/any_edge_o out)
//
//   Parameters:
//     WIDTH        number of independent bits (>= 1)
//     SYNC_STAGES  synchronizer depth, 0..4 (use >= 2 for asynchronous inputs)
//     RESET_VAL    reset level for every flop of every bit
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module edge_to_en #(
    parameter int   WIDTH       = 1,
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    edge_to_en_if.slave  bus
);

    if (WIDTH < 1) begin : g_bad_width
        $error("edge_to_en: WIDTH must be at least 1");
    end

    if (SYNC_STAGES < 0 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("edge_to_en: SYNC_STAGES must be in the range 0..4");
    end

    localparam logic [WIDTH-1:0] RST_VEC = {WIDTH{RESET_VAL}};

    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] prev_q;

    if (SYNC_STAGES == 0) begin : g_direct
        assign cur = bus.data_i;
    end else begin : g_sync
        logic [WIDTH-1:0] sync_q [SYNC_STAGES];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int k = 0; k < SYNC_STAGES; k++) begin
                    sync_q[k] <= RST_VEC;
                end
            end else begin
                sync_q[0] <= bus.data_i;
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    sync_q[k] <= sync_q[k-1];
                end
            end
        end

        assign cur = sync_q[SYNC_STAGES-1];
    end

    // History flop. After reset it holds RESET_VAL, so an input that differs
    // from RESET_VAL at release yields one pulse after the normal latency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= RST_VEC;
        end else begin
            prev_q <= cur;
        end
    end

    // Outputs are masked during reset; this matters for SYNC_STAGES=0 where
    // cur is the live input and would otherwise leak through.
    assign bus.pos_edge_o = rst_i ? '0 : (cur & ~prev_q);
    assign bus.neg_edge_o = rst_i ? '0 : (~cur & prev_q);
    assign bus.any_edge_o = rst_i ? '0 : (cur ^ prev_q);

endmodule

// File: tb/tb_edge_to_en.sv
`timescale 1ns/100ps
module tb_edge_to_en;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst;
    always #2.5 clk = ~clk;

    // Five detector instances:
    //   0: WIDTH=4 SYNC=2 RV=0   1: WIDTH=1 SYNC=0 RV=0   2: WIDTH=1 SYNC=1 RV=0
    //   3: WIDTH=1 SYNC=3 RV=0   4: WIDTH=1 SYNC=2 RV=1
    localparam int NI = 5;
    localparam int SYNC_OF [NI] = '{2, 0, 1, 3, 2};

    logic [3:0] din  [NI];
    logic [3:0] pos  [NI];
    logic [3:0] neg  [NI];
    logic [3:0] any_e[NI];

    edge_to_en_if #(.WIDTH(4)) if0 ();
    edge_to_en_if #(.WIDTH(1)) if1 ();
    edge_to_en_if #(.WIDTH(1)) if2 ();
    edge_to_en_if #(.WIDTH(1)) if3 ();
    edge_to_en_if #(.WIDTH(1)) if4 ();

    assign if0.data_i = din[0];
    assign if1.data_i = din[1][0];
    assign if2.data_i = din[2][0];
    assign if3.data_i = din[3][0];
    assign if4.data_i = din[4][0];

    assign pos[0] = if0.pos_edge_o;           assign neg[0] = if0.neg_edge_o;           assign any_e[0] = if0.any_edge_o;
    assign pos[1] = {3'b000, if1.pos_edge_o}; assign neg[1] = {3'b000, if1.neg_edge_o}; assign any_e[1] = {3'b000, if1.any_edge_o};
    assign pos[2] = {3'b000, if2.pos_edge_o}; assign neg[2] = {3'b000, if2.neg_edge_o}; assign any_e[2] = {3'b000, if2.any_edge_o};
    assign pos[3] = {3'b000, if3.pos_edge_o}; assign neg[3] = {3'b000, if3.neg_edge_o}; assign any_e[3] = {3'b000, if3.any_edge_o};
    assign pos[4] = {3'b000, if4.pos_edge_o}; assign neg[4] = {3'b000, if4.neg_edge_o}; assign any_e[4] = {3'b000, if4.any_edge_o};

    edge_to_en #(.WIDTH(4), .SYNC_STAGES(2), .RESET_VAL(1'b0)) u_dut0 (.clk_i(clk), .rst_i(rst), .bus(if0));
    edge_to_en #(.WIDTH(1), .SYNC_STAGES(0), .RESET_VAL(1'b0)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));
    edge_to_en #(.WIDTH(1), .SYNC_STAGES(1), .RESET_VAL(1'b0)) u_dut2 (.clk_i(clk), .rst_i(rst), .bus(if2));
    edge_to_en #(.WIDTH(1), .SYNC_STAGES(3), .RESET_VAL(1'b0)) u_dut3 (.clk_i(clk), .rst_i(rst), .bus(if3));
    edge_to_en #(.WIDTH(1), .SYNC_STAGES(2), .RESET_VAL(1'b1)) u_dut4 (.clk_i(clk), .rst_i(rst), .bus(if4));

    // ---------------------------------------------------------------- scoreboard
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    // Each instance remembers the input level it saw at each of the last five
    // clock edges (index 0 = most recent). A reset edge makes the remembered
    // history equal to RESET_VAL. The detector's "current" level is the input
    // from SYNC edges ago (the live input when SYNC=0), and its "previous"
    // level is the one from one edge before that.
    logic [3:0] seen [NI][5];

    function automatic logic [3:0] mask_of(input int i);
        return (i == 0) ? 4'hF : 4'h1;
    endfunction

    function automatic logic [3:0] rv_of(input int i);
        return (i == 4) ? mask_of(i) : 4'h0;
    endfunction

    task automatic check_model();
        logic [3:0] c, p, m;
        for (int i = 0; i < NI; i++) begin
            m = mask_of(i);
            c = (SYNC_OF[i] == 0) ? (din[i] & m) : seen[i][SYNC_OF[i]-1];
            p = seen[i][SYNC_OF[i]];
            chk($sformatf("model_pos[%0d]", i), pos[i],   rst ? 4'h0 : ( c & ~p & m));
            chk($sformatf("model_neg[%0d]", i), neg[i],   rst ? 4'h0 : (~c &  p & m));
            chk($sformatf("model_any[%0d]", i), any_e[i], rst ? 4'h0 : ((c ^ p) & m));
        end
    endtask

    task automatic record_edge();
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                for (int k = 0; k < 5; k++) seen[i][k] = rv_of(i);
            end else begin
                for (int k = 4; k > 0; k--) seen[i][k] = seen[i][k-1];
                seen[i][0] = din[i] & mask_of(i);
            end
        end
    endtask

    // Inputs are driven at the falling edge; outputs are checked 1 ns later.
    task automatic settle();
        #1;
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        record_edge();
        @(negedge clk);
    endtask

    // ---------------------------------------------------------------- vector table
    typedef struct {
        logic       rst;
        logic [3:0] data;
        logic [3:0] pos;
        logic [3:0] neg;
        logic [3:0] any;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    int pc, nc, ac, wv;
    logic last_any;

    initial begin
        // Instance 0 (SYNC=2): a change set in row r shows in row r+2.
        tbl[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[1]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[2]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[3]  = '{1'b0, 4'h5, 4'h0, 4'h0, 4'h0};
        tbl[4]  = '{1'b0, 4'h5, 4'h0, 4'h0, 4'h0};
        tbl[5]  = '{1'b0, 4'h5, 4'h5, 4'h0, 4'h5};
        tbl[6]  = '{1'b0, 4'h5, 4'h0, 4'h0, 4'h0};
        tbl[7]  = '{1'b0, 4'hC, 4'h0, 4'h0, 4'h0};
        tbl[8]  = '{1'b0, 4'hC, 4'h0, 4'h0, 4'h0};
        tbl[9]  = '{1'b0, 4'hC, 4'h8, 4'h1, 4'h9};
        tbl[10] = '{1'b0, 4'hC, 4'h0, 4'h0, 4'h0};
        tbl[11] = '{1'b0, 4'hC, 4'h0, 4'h0, 4'h0};
        tbl[12] = '{1'b1, 4'hC, 4'h0, 4'h0, 4'h0};
        tbl[13] = '{1'b1, 4'hC, 4'h0, 4'h0, 4'h0};
        tbl[14] = '{1'b0, 4'hC, 4'h0, 4'h0, 4'h0};
        tbl[15] = '{1'b0, 4'hC, 4'h0, 4'h0, 4'h0};
        tbl[16] = '{1'b0, 4'hC, 4'hC, 4'h0, 4'hC};
        tbl[17] = '{1'b0, 4'hC, 4'h0, 4'h0, 4'h0};
        tbl[18] = '{1'b0, 4'hC, 4'h0, 4'h0, 4'h0};

        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            din[i] = 4'h0;
            for (int k = 0; k < 5; k++) seen[i][k] = rv_of(i);
        end
        @(negedge clk);

        // ---- table: WIDTH=4 pattern and reset with a level held across it
        for (int r = 0; r < NV; r++) begin
            rst    = tbl[r].rst;
            din[0] = tbl[r].data;
            din[1] = {3'b000, tbl[r].data[0]};
            din[2] = {3'b000, tbl[r].data[0]};
            din[3] = {3'b000, tbl[r].data[0]};
            din[4] = 4'h1;
            settle();
            chk($sformatf("tbl_pos[%0d]", r), pos[0],   tbl[r].pos);
            chk($sformatf("tbl_neg[%0d]", r), neg[0],   tbl[r].neg);
            chk($sformatf("tbl_any[%0d]", r), any_e[0], tbl[r].any);
            advance();
        end

        // ---- latency per synchronizer depth; RESET_VAL=1 instance held at 1
        rst = 1'b1;
        for (int i = 0; i < 4; i++) din[i] = 4'h0;
        din[4] = 4'h1;
        repeat (2) begin settle(); chk("rst_any0", any_e[0], 4'h0); advance(); end
        rst = 1'b0;
        repeat (4) begin settle(); chk("rv1_quiet", any_e[4], 4'h0); advance(); end
        for (int i = 0; i < 4; i++) din[i] = 4'h1;
        for (int k = 0; k < 6; k++) begin
            settle();
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("lat_s%0d_k%0d", SYNC_OF[i], k), {31'd0, pos[i][0]},
                    (k == SYNC_OF[i]) ? 32'd1 : 32'd0);
            end
            chk($sformatf("rv1_quiet_k%0d", k), any_e[4], 4'h0);
            advance();
        end

        // ---- toggle every clock on instance 0 bit 0 (starts at level 1)
        for (int j = 0; j < 10; j++) begin
            din[0][0] = ~din[0][0];
            settle();
            if (j >= 2) begin
                chk($sformatf("tog_any%0d", j), {31'd0, any_e[0][0]}, 32'd1);
                chk($sformatf("tog_pos%0d", j), {31'd0, pos[0][0]}, ((j - 2) % 2 == 1) ? 32'd1 : 32'd0);
                chk($sformatf("tog_neg%0d", j), {31'd0, neg[0][0]}, ((j - 2) % 2 == 1) ? 32'd0 : 32'd1);
            end
            advance();
        end

        // ---- asynchronous 12 ns toggles against the 5 ns clock
        din[0] = 4'h0;
        repeat (4) begin settle(); advance(); end
        pc = 0; nc = 0; ac = 0; wv = 0; last_any = 1'b0;
        fork
            begin
                repeat (4) begin #12; din[0][0] = ~din[0][0]; end
            end
            begin
                repeat (16) begin
                    @(negedge clk); #1;
                    pc += int'(pos[0][0]);
                    nc += int'(neg[0][0]);
                    ac += int'(any_e[0][0]);
                    if (any_e[0][0] && last_any) wv++;
                    last_any = any_e[0][0];
                end
            end
        join
        chk("async_pos_count", pc, 2);
        chk("async_neg_count", nc, 2);
        chk("async_any_count", ac, 4);
        chk("async_width_1",   wv, 0);

        // ---- resynchronise the model through a reset, then random traffic
        @(negedge clk);
        rst = 1'b1;
        repeat (2) begin settle(); advance(); end
        rst = 1'b0;
        repeat (300) begin
            rst = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < NI; i++) din[i] = 4'($urandom) & mask_of(i);
            settle();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
